// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Two-requester arbiter and sequencer for the shared data memory.
// Requester 0 is the core load/store path. Requester 1 is the program/debug loader.
// Only one transaction is in flight at a time. The memory port is driven from registers.
// Read data returns three cycles after the grant.
// Optional macro MEM_PORT_ARB_FIXED_PRIO_EN: when it is defined, the loader always
// wins contention. When it is not defined, arbitration is round-robin.

module mem_port_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic grant_any;
    logic grant_id;
    logic win_id;

`ifndef MEM_PORT_ARB_FIXED_PRIO_EN
    logic last_gnt;
`endif

    // Pick the requester that would win if a grant were given this cycle
    always_comb begin
        grant_id = 1'b0;
`ifdef MEM_PORT_ARB_FIXED_PRIO_EN
        grant_id = l_req;
`else
        if (c_req && l_req) begin
            grant_id = ~last_gnt;
        end else begin
            grant_id = l_req;
        end
`endif
    end

    // Next-state logic, grant strobes and read-valid strobes
    always_comb begin
        next_state = state;
        grant_any  = 1'b0;
        c_gnt      = 1'b0;
        l_gnt      = 1'b0;
        c_rvalid   = 1'b0;
        l_rvalid   = 1'b0;
        case (state)
            IDLE: begin
                if (!reset && (c_req || l_req)) begin
                    grant_any  = 1'b1;
                    c_gnt      = ~grant_id;
                    l_gnt      = grant_id;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                next_state = m_we ? IDLE : WAIT;
            end
            WAIT: begin
                next_state = RESP;
            end
            RESP: begin
                c_rvalid   = ~reset & ~win_id;
                l_rvalid   = ~reset & win_id;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Remember which requester owns the current transaction, and who won last
`ifdef MEM_PORT_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            win_id <= 1'b0;
        end else if (grant_any) begin
            win_id <= grant_id;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            win_id   <= 1'b0;
            last_gnt <= 1'b1;
        end else if (grant_any) begin
            win_id   <= grant_id;
            last_gnt <= grant_id;
        end
    end
`endif

    // Memory port registers: load the winning request on grant, strobe for one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else if (grant_any) begin
            m_en    <= 1'b1;
            m_we    <= grant_id ? l_we    : c_we;
            m_addr  <= grant_id ? l_addr  : c_addr;
            m_wdata <= grant_id ? l_wdata : c_wdata;
        end else begin
            m_en    <= 1'b0;
        end
    end

    // Capture read data into the owning requester's response register (kept across reset)
    always_ff @(posedge clk) begin
        if (!reset && state == WAIT) begin
            if (win_id) begin
                l_rdata <= m_rdata;
            end else begin
                c_rdata <= m_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter.
// A driver process replays per-requester command queues.
// A transaction-level model predicts grants and pushes expected memory accesses and read
// responses into queues. A separate monitor pops those queues and checks the DUT outputs.

module tb_mem_port_arbiter;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              c_req, c_we, c_gnt, c_rvalid;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata, c_rdata;
    logic              l_req, l_we, l_gnt, l_rvalid;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata, l_rdata;
    logic              m_en, m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_rdata;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                gap;
    } cmd_t;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                due;
    } mexp_t;

    typedef struct {
        logic              who;
        logic [DATA_W-1:0] data;
        int                due;
    } rexp_t;

    cmd_t  cq[$];
    cmd_t  lq[$];
    mexp_t mq[$];
    rexp_t rq[$];

    bit active [2];
    bit loaded [2];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] init_word(input int i);
        if (i == 3) return 64'h42;
        return {32'hA5A50000 + i[31:0], 32'h01010101 * i[31:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h, want %h", name, cyc, actual, expected);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s at cycle %0d", name, cyc);
    endtask

    task automatic applyStimulus(input bit who, input logic we, input int addr,
                                 input logic [DATA_W-1:0] wdata, input int gap);
        cmd_t c;
        c.we    = we;
        c.addr  = addr[ADDR_W-1:0];
        c.wdata = wdata;
        c.gap   = gap;
        if (who) lq.push_back(c);
        else     cq.push_back(c);
    endtask

    task automatic wait_quiet(input int limit);
        int n = 0;
        while ((cq.size() != 0 || lq.size() != 0 || active[0] || active[1] || loaded[0] || loaded[1]
                || mq.size() != 0 || rq.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) note_fail("quiet_timeout");
        repeat (2) @(negedge clk);
    endtask

    // Synchronous-read memory seen by the arbiter
    initial begin : memory
        logic [DATA_W-1:0] mem [1<<ADDR_W];
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (m_en) begin
                if (m_we) mem[m_addr] = m_wdata;
                else      m_rdata <= mem[m_addr];
            end
        end
    end

    // Requester driver: hold each request until its grant is seen, then move on
    initial begin : driver
        cmd_t cur [2];
        bit   granted [2];
        int   gap_left [2];
        int   waited [2];
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
        for (int i = 0; i < 2; i++) begin
            cur[i].we = 0; cur[i].addr = '0; cur[i].wdata = '0; cur[i].gap = 0;
            gap_left[i] = 0; waited[i] = 0;
        end
        forever begin
            @(negedge clk);
            granted[0] = c_gnt;
            granted[1] = l_gnt;
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (active[i]) begin
                    if (granted[i]) begin
                        active[i] = 0;
                    end else begin
                        waited[i]++;
                        if (waited[i] > 300) begin
                            note_fail("req_timeout");
                            active[i] = 0;
                        end
                    end
                end
                if (!active[i]) begin
                    if (!loaded[i]) begin
                        if (i == 0 && cq.size() != 0) begin
                            cur[0] = cq.pop_front(); loaded[0] = 1; gap_left[0] = cur[0].gap;
                        end else if (i == 1 && lq.size() != 0) begin
                            cur[1] = lq.pop_front(); loaded[1] = 1; gap_left[1] = cur[1].gap;
                        end
                    end
                    if (loaded[i]) begin
                        if (gap_left[i] == 0) begin
                            active[i] = 1; loaded[i] = 0; waited[i] = 0;
                        end else begin
                            gap_left[i]--;
                        end
                    end
                end
            end
            c_req = active[0]; c_we = cur[0].we; c_addr = cur[0].addr; c_wdata = cur[0].wdata;
            l_req = active[1]; l_we = cur[1].we; l_addr = cur[1].addr; l_wdata = cur[1].wdata;
        end
    end

    // Reference model: grant prediction and expected accesses and responses
    initial begin : model
        logic [DATA_W-1:0] ref_mem [1<<ADDR_W];
        int                free_at;
        bit                last;
        bit                win;
        mexp_t             me;
        rexp_t             re;
        free_at = 0;
        last    = 1;
        for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (reset) begin
                checkOutput("gnt_in_reset", {62'd0, c_gnt, l_gnt}, 64'd0);
                mq.delete();
                rq.delete();
                free_at = cyc + 1;
                last    = 1;
            end else if (cyc >= free_at && (c_req || l_req)) begin
                if (c_req && l_req) begin
`ifdef MEM_PORT_ARB_FIXED_PRIO_EN
                    win = 1;
`else
                    win = (last == 0);
`endif
                end else if (c_req) begin
                    win = 0;
                end else begin
                    win = 1;
                end
                checkOutput("gnt", {62'd0, c_gnt, l_gnt}, win ? 64'd1 : 64'd2);
                last     = win;
                me.we    = win ? l_we : c_we;
                me.addr  = win ? l_addr : c_addr;
                me.wdata = win ? l_wdata : c_wdata;
                me.due   = cyc + 1;
                mq.push_back(me);
                if (me.we) begin
                    ref_mem[me.addr] = me.wdata;
                    free_at = cyc + 2;
                end else begin
                    re.who  = win;
                    re.data = ref_mem[me.addr];
                    re.due  = cyc + 3;
                    rq.push_back(re);
                    free_at = cyc + 4;
                end
            end else begin
                checkOutput("no_gnt", {62'd0, c_gnt, l_gnt}, 64'd0);
            end
        end
    end

    // Monitor: compare memory strobes and read responses against the expected queues
    initial begin : monitor
        bit    prev_reset;
        mexp_t me;
        rexp_t re;
        prev_reset = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                checkOutput("rvalid_in_reset", {62'd0, c_rvalid, l_rvalid}, 64'd0);
            end else begin
                if (prev_reset) begin
                    checkOutput("rst_m_en", {63'd0, m_en}, 64'd0);
                    checkOutput("rst_m_we", {63'd0, m_we}, 64'd0);
                    checkOutput("rst_m_addr", {58'd0, m_addr}, 64'd0);
                    checkOutput("rst_m_wdata", m_wdata, 64'd0);
                end
                if (m_en) begin
                    if (mq.size() == 0) begin
                        note_fail("unexpected_m_en");
                    end else begin
                        me = mq.pop_front();
                        checkOutput("m_en_cycle", 64'(cyc), 64'(me.due));
                        checkOutput("m_we", {63'd0, m_we}, {63'd0, me.we});
                        checkOutput("m_addr", {58'd0, m_addr}, {58'd0, me.addr});
                        if (me.we) checkOutput("m_wdata", m_wdata, me.wdata);
                    end
                end
                if (c_rvalid && l_rvalid) note_fail("both_rvalid");
                if (c_rvalid || l_rvalid) begin
                    if (rq.size() == 0) begin
                        note_fail("unexpected_rvalid");
                    end else begin
                        re = rq.pop_front();
                        checkOutput("rvalid_cycle", 64'(cyc), 64'(re.due));
                        checkOutput("rvalid_who", {63'd0, l_rvalid}, {63'd0, re.who});
                        checkOutput("rdata", re.who ? l_rdata : c_rdata, re.data);
                    end
                end
                while (mq.size() != 0 && mq[0].due < cyc) begin
                    note_fail("m_en_missing");
                    void'(mq.pop_front());
                end
                while (rq.size() != 0 && rq[0].due < cyc) begin
                    note_fail("rvalid_missing");
                    void'(rq.pop_front());
                end
            end
            prev_reset = reset;
        end
    end

    // Directed scenarios followed by a randomized mix
    initial begin : main
        int n;
        reset = 1;
        repeat (4) @(posedge clk);
        #1 reset = 0;
        repeat (2) @(negedge clk);

        $display("[TB] core write then read of addr 5");
        applyStimulus(0, 1, 5, 64'hDEADBEEF_00000001, 0);
        applyStimulus(0, 0, 5, 64'd0, 0);
        wait_quiet(200);

        $display("[TB] contention with writes");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 10 + i, 64'h1000 + 64'(i), 0);
            applyStimulus(1, 1, 20 + i, 64'h2000 + 64'(i), 0);
        end
        wait_quiet(200);

        $display("[TB] loader read while core waits");
        applyStimulus(1, 0, 3, 64'd0, 0);
        applyStimulus(0, 1, 7, 64'h77, 1);
        wait_quiet(200);

        $display("[TB] reset during a read");
        applyStimulus(0, 0, 9, 64'd0, 0);
        applyStimulus(0, 1, 9, 64'h9999, 2);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!c_gnt && n < 50);
        if (!c_gnt) note_fail("reset_test_gnt_timeout");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1;
        @(posedge clk);
        #1 reset = 0;
        applyStimulus(0, 0, 9, 64'd0, 0);
        wait_quiet(200);

        $display("[TB] back-to-back core writes");
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, i, 64'hB000 + 64'(i), 0);
        applyStimulus(0, 0, 2, 64'd0, 0);
        wait_quiet(200);

        $display("[TB] random traffic");
        for (int i = 0; i < 150; i++) begin
            applyStimulus(0, 1'($urandom_range(0, 1)), $urandom_range(0, 63),
                          {$urandom, $urandom}, $urandom_range(0, 3));
            applyStimulus(1, 1'($urandom_range(0, 1)), $urandom_range(0, 63),
                          {$urandom, $urandom}, $urandom_range(0, 3));
        end
        wait_quiet(10000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
